// File: rtl/disp_pkg.sv
// disp_pkg: shared types and constants for the display scheduler.
// Holds the scheduler state enum, the source-id codes driven on owner,
// and the all-digits-blank mask.
package disp_pkg;

    typedef enum logic [1:0] {
        SHOW0,
        GAP,
        HOLD
    } state_t;

    localparam logic [1:0] SRC_DEF  = 2'd0;
    localparam logic [1:0] SRC_T    = 2'd1;
    localparam logic [1:0] SRC_M    = 2'd2;
    localparam logic [1:0] SRC_NONE = 2'd3;

    localparam logic [3:0] BLANK_ALL = 4'hF;

endpackage

// File: rtl/disp_tick_gen.sv
// disp_tick_gen: prescaler producing a one-clk tick every TICK_DIV cycles.
// Ports: clk, rst (sync, active-high), tick (one-cycle pulse).
// The first tick after reset appears in cycle TICK_DIV-1.
module disp_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);

    logic [W-1:0] r_cnt;
    logic         w_wrap;

    assign w_wrap = r_cnt == W'(TICK_DIV - 1);
    assign tick   = w_wrap;

    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/disp_sched.sv
// disp_sched: shares one 4-digit seven-segment path between three sources.
// Ports: clk, rst (sync, active-high); data0 default digits;
//        req1/data1/ack1 and req2/data2/ack2 borrow handshakes (source 2 wins);
//        digits/blank to the display driver; owner (3 = gap); busy.
// Optional: define DISP_SCHED_BLINK_EN to blink the display during HOLD.
module disp_sched
    import disp_pkg::*;
#(
    parameter int TICK_DIV    = 100000,
    parameter int HOLD_TICKS  = 1500,
    parameter int BLANK_TICKS = 50,
    parameter int BLINK_TICKS = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        ack1,
    input  logic        req2,
    input  logic [15:0] data2,
    output logic        ack2,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [1:0]  owner,
    output logic        busy
);

    localparam int MAX_HB = HOLD_TICKS > BLANK_TICKS ? HOLD_TICKS : BLANK_TICKS;
    localparam int MAXT   = MAX_HB > BLINK_TICKS ? MAX_HB : BLINK_TICKS;
    localparam int CW     = $clog2(MAXT + 1);

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          r_fresh;
    logic          r_pend;
    logic [1:0]    r_win;
    logic [15:0]   r_data, r_digits;
    logic          r_ack1, r_ack2;
    logic          w_tick, w_cnt_tick, w_gap_done, w_hold_done, w_arb, w_acc, w_trans;
    logic [3:0]    w_hold_blank;

    disp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // r_fresh marks the first cycle of a state so a tick landing there is ignored.
    assign w_cnt_tick  = w_tick & ~r_fresh;
    assign w_gap_done  = r_state == GAP  && w_cnt_tick && r_cnt == CW'(BLANK_TICKS - 1);
    assign w_hold_done = r_state == HOLD && w_cnt_tick && r_cnt == CW'(HOLD_TICKS - 1);
    assign w_arb       = r_state == SHOW0 || w_hold_done;
    assign w_acc       = w_arb && (req1 || req2);
    assign w_trans     = w_next != r_state;

    always_comb begin
        w_next = r_state;
        if (w_acc || w_hold_done) w_next = GAP;
        else if (w_gap_done)      w_next = r_pend ? HOLD : SHOW0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= SHOW0;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_fresh  <= 1'b0;
            r_pend   <= 1'b0;
            r_win    <= SRC_DEF;
            r_data   <= '0;
            r_digits <= '0;
            r_ack1   <= 1'b0;
            r_ack2   <= 1'b0;
        end else begin
            r_fresh  <= w_trans;
            r_cnt    <= w_trans ? '0 : (w_cnt_tick && r_state != SHOW0) ? r_cnt + 1'b1 : r_cnt;
            r_ack1   <= w_acc && !req2;
            r_ack2   <= w_acc && req2;
            r_pend   <= w_acc ? 1'b1 : w_hold_done ? 1'b0 : r_pend;
            r_data   <= w_acc ? (req2 ? data2 : data1) : r_data;
            r_win    <= w_acc ? (req2 ? SRC_M : SRC_T) : r_win;
            // Digits freeze through the gap and pick up the borrowed word as HOLD begins.
            r_digits <= r_state == SHOW0 ? data0 : (w_gap_done && r_pend) ? r_data : r_digits;
        end
    end

`ifdef DISP_SCHED_BLINK_EN
    logic [CW-1:0] r_bcnt;
    logic          r_blink;
    logic          w_bwrap;

    assign w_bwrap = r_bcnt == CW'(BLINK_TICKS - 1);

    // Blink phase restarts visible on every HOLD entry and is forced visible outside HOLD.
    always_ff @(posedge clk) begin
        if (rst || r_state != HOLD || w_trans) begin
            r_bcnt  <= '0;
            r_blink <= 1'b0;
        end else if (w_cnt_tick) begin
            r_bcnt  <= w_bwrap ? '0 : r_bcnt + 1'b1;
            r_blink <= r_blink ^ w_bwrap;
        end
    end

    assign w_hold_blank = {4{r_blink}};
`else
    assign w_hold_blank = 4'h0;
`endif

    assign digits = r_digits;
    assign blank  = r_state == GAP ? BLANK_ALL : r_state == HOLD ? w_hold_blank : 4'h0;
    assign owner  = r_state == GAP ? SRC_NONE : r_state == HOLD ? r_win : SRC_DEF;
    assign busy   = r_state != SHOW0;
    assign ack1   = r_ack1;
    assign ack2   = r_ack2;

endmodule

// File: doc/disp_sched.md
Name: disp_sched

Overview:
- Scheduler that shares the single 4-digit seven-segment display path between three sources.
- Source 0 is the default owner (e.g. score). Source 1 (e.g. timer) and source 2 (e.g. message) request temporary ownership through a req/ack handshake.
- The block owns a digit word and a per-digit blank mask. It sits directly upstream of the scan/decode display driver.
- A blank gap separates every ownership change, and each borrowed ownership lasts a fixed hold time.

Parameters:
- TICK_DIV, 100000, clk cycles per scheduler tick (1 ms at 100 MHz); must be >= 2.
- HOLD_TICKS, 1500, ticks a borrowing source keeps the display; must be >= 1.
- BLANK_TICKS, 50, ticks of all-blank gap on every ownership change; must be >= 1.
- BLINK_TICKS, 250, half-period in ticks of the optional blink.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- data0  input  16  default-source digits, four 4-bit hex nibbles, [15:12] leftmost
- req1  input  1  source 1 request, level, held until ack1
- data1  input  16  source 1 digits, sampled in the cycle req1 is accepted
- ack1  output  1  one-cycle accept pulse for source 1
- req2  input  1  source 2 request, level, held until ack2
- data2  input  16  source 2 digits, sampled in the cycle req2 is accepted
- ack2  output  1  one-cycle accept pulse for source 2
- digits  output  16  registered word to the display driver
- blank  output  4  per-digit blank; 1 = anode forced off, bit 3 = leftmost
- owner  output  2  current owner: 0, 1 or 2; 3 during the gap
- busy  output  1  high whenever state is not SHOW0

Behaviour:
- Reset values: state SHOW0, digits=0, blank=0, owner=0, ack1=ack2=0, busy=0. The tick prescaler, tick counter and latched data are all cleared.
- Tick generation: an internal prescaler asserts tick for one clk every TICK_DIV cycles. Both timers below count ticks only; they never count clk cycles.
- SHOW0: digits<=data0 every cycle (1-cycle latency), blank=0, owner=0.
- Arbitration is sampled only in SHOW0 and at HOLD expiry. Source 2 has priority over source 1, and there is no preemption.
- Accepting a request in cycle n:
  - The winner's data is latched in cycle n.
  - The winner's ack is high in cycle n+1 only.
  - State becomes GAP in cycle n+1.
  - The loser keeps its req high and receives no ack.
- GAP: blank=4'hF, owner=3, digits hold their previous value. The tick counter clears on entry; ticks are counted from the cycle after entry.
  - After BLANK_TICKS ticks, go to HOLD if a request was latched, else go to SHOW0.
- HOLD: digits=latched data, blank=0, owner=winner id. The tick counter clears on entry.
  - On the HOLD_TICKS-th tick, if req2 or req1 is pending, accept it per the rule above (ack next cycle, then GAP, then HOLD).
  - Otherwise go to GAP with nothing latched, then SHOW0.
- req rising during GAP or HOLD: no ack. The request waits for the next arbitration point.
- req dropped before ack: the request is withdrawn and never served.
- req1 and req2 rising in the same cycle: source 2 wins and source 1 is served after source 2's hold.
- A tick in the same cycle as a state entry is not counted.
- Reset mid-operation returns to SHOW0 on the next edge. Pending acks are not issued and latched data is discarded.

Optional Feature:
- Macro: DISP_SCHED_BLINK_EN.
- Defined: during HOLD, blank toggles between 4'h0 and 4'hF every BLINK_TICKS ticks, starting visible (4'h0) on HOLD entry. digits are unaffected, and the blink is forced visible on leaving HOLD.
- Undefined: no blink logic is built, and blank is 4'h0 throughout HOLD.

Decomposition:
- Package disp_pkg holds:
  - the state enum {SHOW0, GAP, HOLD};
  - source-id constants SRC_DEF=0, SRC_T=1, SRC_M=2, SRC_NONE=3;
  - the constant BLANK_ALL=4'hF.
- Sub-module disp_tick_gen: the TICK_DIV prescaler with clk, rst and tick output, counter width $clog2(TICK_DIV).

Test Plan (TICK_DIV=4, HOLD_TICKS=3, BLANK_TICKS=1, BLINK_TICKS=1):
- Reset, then data0=16'h1234 for 10 cycles -> digits=16'h1234 one cycle after data0 settles, blank=0, owner=0, busy=0.
- req1 with data1=16'hABCD in SHOW0 -> ack1 a single pulse next cycle, then blank=F and owner=3 for 1 tick, then digits=ABCD and owner=1 for 3 ticks, then 1 tick blank, then data0 shown.
- req1 and req2 rise together (data2=16'h0E0E) -> ack2 first and owner=2 held for 3 ticks; ack1 issued at HOLD expiry and owner=1 after the gap; no ack overlap.
- req1 drops during HOLD of source 2 -> ack1 never asserts and the block returns to SHOW0 after the gap.
- rst asserted mid-HOLD with req1 pending -> next cycle state SHOW0, digits=0, no ack1, busy=0.
- DISP_SCHED_BLINK_EN defined, req2 served -> blank sequence 0,F,0 across the 3 HOLD ticks, and blank=0 after return to SHOW0.
